// File: rtl/service_rd_xbar.sv
// rtl/service_rd_xbar.sv - read-only AR/R service crossbar with address map, RR arbitration, ordering guard and decode-error responder (optional SERVICE_RD_XBAR_PERF_EN)
module service_rd_xbar #(
    parameter int NumClusters = 4,
    parameter int NumTargets  = 2,
    parameter int AddrWidth   = 32,
    parameter int IdWidth     = 4,
    parameter int DataWidth   = 64,
    parameter int MaxTxns     = 8,
    localparam int CIW        = (NumClusters > 1) ? $clog2(NumClusters) : 1,
    localparam int MIW        = IdWidth + CIW
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumTargets*AddrWidth-1:0] rule_start_i,
    input  logic [NumTargets*AddrWidth-1:0] rule_end_i,
    input  logic [NumClusters-1:0]          slv_ar_valid_i,
    output logic [NumClusters-1:0]          slv_ar_ready_o,
    input  logic [NumClusters*AddrWidth-1:0] slv_ar_addr_i,
    input  logic [NumClusters*IdWidth-1:0]  slv_ar_id_i,
    input  logic [NumClusters*8-1:0]        slv_ar_len_i,
    output logic [NumClusters-1:0]          slv_r_valid_o,
    input  logic [NumClusters-1:0]          slv_r_ready_i,
    output logic [NumClusters*DataWidth-1:0] slv_r_data_o,
    output logic [NumClusters*IdWidth-1:0]  slv_r_id_o,
    output logic [NumClusters*2-1:0]        slv_r_resp_o,
    output logic [NumClusters-1:0]          slv_r_last_o,
    output logic [NumTargets-1:0]           mst_ar_valid_o,
    input  logic [NumTargets-1:0]           mst_ar_ready_i,
    output logic [NumTargets*AddrWidth-1:0] mst_ar_addr_o,
    output logic [NumTargets*MIW-1:0]       mst_ar_id_o,
    output logic [NumTargets*8-1:0]         mst_ar_len_o,
    input  logic [NumTargets-1:0]           mst_r_valid_i,
    output logic [NumTargets-1:0]           mst_r_ready_o,
    input  logic [NumTargets*DataWidth-1:0] mst_r_data_i,
    input  logic [NumTargets*MIW-1:0]       mst_r_id_i,
    input  logic [NumTargets*2-1:0]         mst_r_resp_i,
    input  logic [NumTargets-1:0]           mst_r_last_i
`ifdef SERVICE_RD_XBAR_PERF_EN
    ,
    output logic [31:0]                     perf_decerr_o,
    output logic [31:0]                     perf_stall_o
`endif
);
    localparam int TW = $clog2(NumTargets + 1);
    localparam int CW = $clog2(MaxTxns + 1);
    localparam logic [TW-1:0] ERR_TGT = TW'(NumTargets);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [AddrWidth-1:0] s_addr [NumClusters];
    logic [IdWidth-1:0]   s_id   [NumClusters];
    logic [7:0]           s_len  [NumClusters];
    logic [TW-1:0]        dec_tgt   [NumClusters];
    logic [CW-1:0]        cnt_q     [NumClusters];
    logic [TW-1:0]        cur_tgt_q [NumClusters];
    logic [NumClusters-1:0] can_issue, elig, c_ar_hs, c_r_done;

    logic [CIW-1:0]       rr_q       [NumTargets+1];
    logic [CIW-1:0]       lock_idx_q [NumTargets+1];
    logic [CIW-1:0]       gnt_idx    [NumTargets+1];
    logic [NumTargets:0]  lock_q, gnt_valid, tgt_ar_ready, tgt_ar_hs;

    logic [NumTargets:0]  tr_valid, tr_ready, tr_last, route_ok;
    logic [MIW-1:0]       tr_id   [NumTargets+1];
    logic [DataWidth-1:0] tr_data [NumTargets+1];
    logic [1:0]           tr_resp [NumTargets+1];

    logic [0:0]           err_state_q;
    logic [MIW-1:0]       err_id_q;
    logic [7:0]           err_len_q, err_beat_q;

    for (genvar c = 0; c < NumClusters; c++) begin : g_unpack
        assign s_addr[c] = slv_ar_addr_i[c*AddrWidth +: AddrWidth];
        assign s_id[c]   = slv_ar_id_i[c*IdWidth +: IdWidth];
        assign s_len[c]  = slv_ar_len_i[c*8 +: 8];
    end

    // Address decode: lowest matching rule wins, empty rules never match, misses go to ERR.
    always_comb begin
        for (int c = 0; c < NumClusters; c++) begin
            dec_tgt[c] = ERR_TGT;
            for (int t = NumTargets - 1; t >= 0; t--) begin
                if (rule_start_i[t*AddrWidth +: AddrWidth] < rule_end_i[t*AddrWidth +: AddrWidth] &&
                    rule_start_i[t*AddrWidth +: AddrWidth] <= s_addr[c] &&
                    s_addr[c] < rule_end_i[t*AddrWidth +: AddrWidth])
                    dec_tgt[c] = TW'(t);
            end
        end
    end

    // Ordering guard: a cluster only issues to the target its outstanding reads already use.
    always_comb begin
        for (int c = 0; c < NumClusters; c++) begin
            can_issue[c] = (cnt_q[c] < CW'(MaxTxns)) &&
                           (cnt_q[c] == '0 || dec_tgt[c] == cur_tgt_q[c]);
            elig[c]      = slv_ar_valid_i[c] && can_issue[c];
        end
    end

    // Per-target round-robin pick; a pending grant is held until its handshake.
    always_comb begin
        int idx;
        idx = 0;
        for (int t = 0; t <= NumTargets; t++) begin
            gnt_valid[t] = 1'b0;
            gnt_idx[t]   = '0;
            if (lock_q[t]) begin
                gnt_valid[t] = 1'b1;
                gnt_idx[t]   = lock_idx_q[t];
            end else begin
                for (int i = 0; i < NumClusters; i++) begin
                    idx = (int'(rr_q[t]) + i) % NumClusters;
                    if (!gnt_valid[t] && elig[idx] && dec_tgt[idx] == TW'(t)) begin
                        gnt_valid[t] = 1'b1;
                        gnt_idx[t]   = CIW'(idx);
                    end
                end
            end
        end
    end

    assign tgt_ar_ready = {err_state_q == ST_IDLE, mst_ar_ready_i};
    assign tgt_ar_hs    = gnt_valid & tgt_ar_ready;

    // Return AR ready to whichever cluster won a target that handshakes this cycle.
    always_comb begin
        slv_ar_ready_o = '0;
        for (int t = 0; t <= NumTargets; t++) begin
            if (tgt_ar_hs[t])
                slv_ar_ready_o[gnt_idx[t]] = 1'b1;
        end
    end

    for (genvar t = 0; t < NumTargets; t++) begin : g_mst
        assign mst_ar_valid_o[t]               = gnt_valid[t];
        assign mst_ar_addr_o[t*AddrWidth +: AddrWidth] = s_addr[gnt_idx[t]];
        assign mst_ar_id_o[t*MIW +: MIW]       = {gnt_idx[t], s_id[gnt_idx[t]]};
        assign mst_ar_len_o[t*8 +: 8]          = s_len[gnt_idx[t]];
        assign tr_valid[t]                     = mst_r_valid_i[t];
        assign tr_last[t]                      = mst_r_last_i[t];
        assign tr_id[t]                        = mst_r_id_i[t*MIW +: MIW];
        assign tr_data[t]                      = mst_r_data_i[t*DataWidth +: DataWidth];
        assign tr_resp[t]                      = mst_r_resp_i[t*2 +: 2];
    end

    assign tr_valid[NumTargets] = (err_state_q == ST_RESP);
    assign tr_last[NumTargets]  = (err_beat_q == err_len_q);
    assign tr_id[NumTargets]    = err_id_q;
    assign tr_data[NumTargets]  = '0;
    assign tr_resp[NumTargets]  = 2'b11;

    // Arbiter state: grant lock while stalled, pointer advances past the granted cluster.
    always_ff @(posedge clk_i) begin
        for (int t = 0; t <= NumTargets; t++) begin
            if (rst_i) begin
                rr_q[t]       <= '0;
                lock_q[t]     <= 1'b0;
                lock_idx_q[t] <= '0;
            end else begin
                lock_q[t]     <= gnt_valid[t] && !tgt_ar_ready[t];
                lock_idx_q[t] <= gnt_idx[t];
                if (tgt_ar_hs[t])
                    rr_q[t] <= (gnt_idx[t] == CIW'(NumClusters - 1)) ? '0 : gnt_idx[t] + 1'b1;
            end
        end
    end

    // R ready back to a source only when the ID names a cluster that expects it from that source.
    always_comb begin
        for (int t = 0; t <= NumTargets; t++) begin
            route_ok[t] = 1'b0;
            tr_ready[t] = 1'b0;
            for (int c = 0; c < NumClusters; c++) begin
                if (tr_id[t][MIW-1 -: CIW] == CIW'(c) && cnt_q[c] != '0 && cur_tgt_q[c] == TW'(t)) begin
                    route_ok[t] = 1'b1;
                    tr_ready[t] = slv_r_ready_i[c];
                end
            end
        end
    end

    assign mst_r_ready_o = tr_ready[NumTargets-1:0];

    // Each cluster takes R only from its current target; the cluster ID field is stripped.
    always_comb begin
        slv_r_valid_o = '0;
        slv_r_data_o  = '0;
        slv_r_id_o    = '0;
        slv_r_resp_o  = '0;
        slv_r_last_o  = '0;
        for (int c = 0; c < NumClusters; c++) begin
            for (int t = 0; t <= NumTargets; t++) begin
                if (cnt_q[c] != '0 && cur_tgt_q[c] == TW'(t) && tr_valid[t] &&
                    tr_id[t][MIW-1 -: CIW] == CIW'(c)) begin
                    slv_r_valid_o[c]                       = 1'b1;
                    slv_r_data_o[c*DataWidth +: DataWidth] = tr_data[t];
                    slv_r_id_o[c*IdWidth +: IdWidth]       = tr_id[t][IdWidth-1:0];
                    slv_r_resp_o[c*2 +: 2]                 = tr_resp[t];
                    slv_r_last_o[c]                        = tr_last[t];
                end
            end
        end
    end

    assign c_ar_hs  = slv_ar_valid_i & slv_ar_ready_o;
    assign c_r_done = slv_r_valid_o & slv_r_ready_i & slv_r_last_o;

    // Outstanding-read counters and the target those reads are bound to.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumClusters; c++) begin
            if (rst_i) begin
                cnt_q[c]     <= '0;
                cur_tgt_q[c] <= '0;
            end else begin
                if (c_ar_hs[c] && !c_r_done[c])
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                else if (!c_ar_hs[c] && c_r_done[c])
                    cnt_q[c] <= cnt_q[c] - 1'b1;
                if (c_ar_hs[c] && cnt_q[c] == '0)
                    cur_tgt_q[c] <= dec_tgt[c];
            end
        end
    end

    // Decode-error responder: accept one AR, then stream len+1 zero DECERR beats.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_state_q <= ST_IDLE;
            err_id_q    <= '0;
            err_len_q   <= '0;
            err_beat_q  <= '0;
        end else if (err_state_q == ST_IDLE) begin
            if (tgt_ar_hs[NumTargets]) begin
                err_id_q    <= {gnt_idx[NumTargets], s_id[gnt_idx[NumTargets]]};
                err_len_q   <= s_len[gnt_idx[NumTargets]];
                err_beat_q  <= '0;
                err_state_q <= ST_RESP;
            end
        end else if (tr_ready[NumTargets]) begin
            if (err_beat_q == err_len_q)
                err_state_q <= ST_IDLE;
            else
                err_beat_q <= err_beat_q + 1'b1;
        end
    end

    // A target returning R that no cluster is waiting for is a protocol violation.
    always_ff @(posedge clk_i) begin
        for (int t = 0; t < NumTargets; t++) begin
            if (!rst_i && mst_r_valid_i[t])
                assert (route_ok[t]);
        end
    end

`ifdef SERVICE_RD_XBAR_PERF_EN
    logic [NumClusters-1:0] stall;
    assign stall = slv_ar_valid_i & ~can_issue;

    // Saturating event counters: ERR AR handshakes and guard-stall cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_decerr_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (tgt_ar_hs[NumTargets] && perf_decerr_o != 32'hFFFF_FFFF)
                perf_decerr_o <= perf_decerr_o + 1'b1;
            if (|stall && perf_stall_o != 32'hFFFF_FFFF)
                perf_stall_o <= perf_stall_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_service_rd_xbar.sv
// tb/tb_service_rd_xbar.sv - directed self-checking bench for service_rd_xbar
module tb_service_rd_xbar;
    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  rule_start, rule_end;
    logic [3:0]   s_arv;
    logic [3:0]   s_arr;
    logic [127:0] s_addr;
    logic [15:0]  s_id;
    logic [31:0]  s_len;
    logic [3:0]   s_rv;
    logic [3:0]   s_rr;
    logic [255:0] s_rd;
    logic [15:0]  s_rid;
    logic [7:0]   s_rresp;
    logic [3:0]   s_rlast;
    logic [1:0]   m_arv;
    logic [1:0]   m_arr;
    logic [63:0]  m_addr;
    logic [11:0]  m_id;
    logic [15:0]  m_len;
    logic [1:0]   m_rv;
    logic [1:0]   m_rr;
    logic [127:0] m_rd;
    logic [11:0]  m_rid;
    logic [3:0]   m_rresp;
    logic [1:0]   m_rlast;
`ifdef SERVICE_RD_XBAR_PERF_EN
    logic [31:0]  perf_decerr, perf_stall;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    service_rd_xbar dut (
        .clk_i(clk), .rst_i(rst),
        .rule_start_i(rule_start), .rule_end_i(rule_end),
        .slv_ar_valid_i(s_arv), .slv_ar_ready_o(s_arr), .slv_ar_addr_i(s_addr),
        .slv_ar_id_i(s_id), .slv_ar_len_i(s_len),
        .slv_r_valid_o(s_rv), .slv_r_ready_i(s_rr), .slv_r_data_o(s_rd),
        .slv_r_id_o(s_rid), .slv_r_resp_o(s_rresp), .slv_r_last_o(s_rlast),
        .mst_ar_valid_o(m_arv), .mst_ar_ready_i(m_arr), .mst_ar_addr_o(m_addr),
        .mst_ar_id_o(m_id), .mst_ar_len_o(m_len),
        .mst_r_valid_i(m_rv), .mst_r_ready_o(m_rr), .mst_r_data_i(m_rd),
        .mst_r_id_i(m_rid), .mst_r_resp_i(m_rresp), .mst_r_last_i(m_rlast)
`ifdef SERVICE_RD_XBAR_PERF_EN
        , .perf_decerr_o(perf_decerr), .perf_stall_o(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ar(input int c, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        s_arv[c]         = 1'b1;
        s_addr[c*32 +: 32] = a;
        s_id[c*4 +: 4]   = id;
        s_len[c*8 +: 8]  = len;
    endtask

    task automatic mr(input int t, input logic [1:0] cl, input logic [3:0] id, input logic last,
                      input logic [63:0] d);
        m_rv[t]            = 1'b1;
        m_rid[t*6 +: 6]    = {cl, id};
        m_rd[t*64 +: 64]   = d;
        m_rlast[t]         = last;
        m_rresp[t*2 +: 2]  = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_arv = '0; s_addr = '0; s_id = '0; s_len = '0; s_rr = 4'hF;
        m_arr = 2'b11; m_rv = '0; m_rd = '0; m_rid = '0; m_rresp = '0; m_rlast = '0;
        rule_start = {32'h1000_0000, 32'h1C00_0000};
        rule_end   = {32'h1010_0000, 32'h1C10_0000};
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;
        do_reset();
        check("rst_ar_ready", 64'(s_arr), 64'h0);
        check("rst_mst_valid", 64'(m_arv), 64'h0);
        check("rst_r_valid", 64'(s_rv), 64'h0);

        // Basic route: cluster 2 to target 0 and its response back.
        ar(2, 32'h1C00_0040, 4'd3, 8'd0);
        #1;
        check("t1_mst_valid", 64'(m_arv), 64'h1);
        check("t1_mst_id", 64'(m_id[5:0]), 64'h23);
        check("t1_mst_addr", 64'(m_addr[31:0]), 64'h1C00_0040);
        check("t1_slv_ready", 64'(s_arr), 64'h4);
        step();
        s_arv = '0;
        mr(0, 2'd2, 4'd3, 1'b1, 64'hDEAD_BEEF);
        #1;
        check("t1_r_valid", 64'(s_rv), 64'h4);
        check("t1_r_id", 64'(s_rid[11:8]), 64'h3);
        check("t1_r_data", s_rd[191:128], 64'hDEAD_BEEF);
        check("t1_r_last", 64'(s_rlast), 64'h4);
        check("t1_mst_r_ready", 64'(m_rr), 64'h1);
        step();
        m_rv = '0;
        #1;
        check("t1_r_done", 64'(s_rv), 64'h0);

        // Round robin: all clusters hammer target 1.
        do_reset();
        for (int c = 0; c < 4; c++) ar(c, 32'h1000_0000 + 32'(c) * 32'h100, 4'(c), 8'd0);
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_g = 2'(k % 4);
            check("t2_valid", 64'(m_arv), 64'h2);
            check("t2_grant", 64'(m_id[11:10]), 64'(exp_g));
            check("t2_addr", 64'(m_addr[63:32]), 64'h1000_0000 + 64'(exp_g) * 64'h100);
            check("t2_ready", 64'(s_arr), 64'(4'b0001 << exp_g));
            step();
        end
        s_arv = '0;

        // Outstanding limit: 8 reads accepted, 9th waits for an R-last.
        do_reset();
        ar(0, 32'h1C00_0000, 4'd1, 8'd0);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t3_accept", 64'(s_arr[0]), 64'h1);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            check("t3_stall_ready", 64'(s_arr[0]), 64'h0);
            check("t3_stall_mst", 64'(m_arv[0]), 64'h0);
            step();
        end
        mr(0, 2'd0, 4'd1, 1'b1, 64'h55);
        #1;
        check("t3_r_ready", 64'(m_rr[0]), 64'h1);
        check("t3_r_valid", 64'(s_rv[0]), 64'h1);
        check("t3_no_r2ar", 64'(s_arr[0]), 64'h0);
        step();
        m_rv = '0;
        #1;
`ifdef SERVICE_RD_XBAR_PERF_EN
        check("t3_perf_stall", 64'(perf_stall), 64'd3);
`endif
        check("t3_9th_ready", 64'(s_arr[0]), 64'h1);
        check("t3_9th_mst", 64'(m_arv[0]), 64'h1);
        step();
        s_arv = '0;

        // Ordering guard: switching target waits for the old target to drain.
        do_reset();
        ar(1, 32'h1C00_0100, 4'd7, 8'd0);
        #1;
        check("t4_first", 64'(s_arr), 64'h2);
        step();
        ar(1, 32'h1000_0200, 4'd8, 8'd0);
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t4_stall_ready", 64'(s_arr), 64'h0);
            check("t4_stall_mst", 64'(m_arv), 64'h0);
            step();
        end
        mr(0, 2'd1, 4'd7, 1'b1, 64'h77);
        #1;
        check("t4_r_valid", 64'(s_rv), 64'h2);
        step();
        m_rv = '0;
        #1;
        check("t4_fwd_ready", 64'(s_arr), 64'h2);
        check("t4_fwd_mst", 64'(m_arv), 64'h2);
        check("t4_fwd_id", 64'(m_id[11:6]), 64'h18);
        step();
        s_arv = '0;

        // Decode boundaries and the DECERR burst.
        do_reset();
        ar(0, 32'h1C10_0000, 4'd0, 8'd0);
        #1;
        check("t5_end_excl_mst", 64'(m_arv), 64'h0);
        check("t5_end_excl_err", 64'(s_arr), 64'h1);
        rule_start[63:32] = 32'h1010_0000;
        ar(0, 32'h1008_0000, 4'd0, 8'd0);
        #1;
        check("t5_empty_rule", 64'(m_arv), 64'h0);
        s_arv = '0;
        rule_start[63:32] = 32'h1000_0000;
        ar(3, 32'hF000_0000, 4'd5, 8'd3);
        #1;
        check("t5_err_ready", 64'(s_arr), 64'h8);
        check("t5_err_mst", 64'(m_arv), 64'h0);
        step();
        s_arv = '0;
`ifdef SERVICE_RD_XBAR_PERF_EN
        check("t5_perf_decerr", 64'(perf_decerr), 64'd1);
`endif
        check("t5_err_busy", 64'(s_arr), 64'h0);
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                s_rr = 4'h0;
                step();
                check("t5_hold_valid", 64'(s_rv), 64'h8);
                check("t5_hold_last", 64'(s_rlast[3]), 64'h0);
                s_rr = 4'hF;
                #1;
            end
            check("t5_beat_valid", 64'(s_rv), 64'h8);
            check("t5_beat_resp", 64'(s_rresp[7:6]), 64'h3);
            check("t5_beat_id", 64'(s_rid[15:12]), 64'h5);
            check("t5_beat_data", s_rd[255:192], 64'h0);
            check("t5_beat_last", 64'(s_rlast[3]), 64'(b == 3));
            step();
        end
        check("t5_done", 64'(s_rv), 64'h0);

        // Reset in the middle of a DECERR burst.
        do_reset();
        ar(0, 32'hF000_0000, 4'd1, 8'd3);
        step();
        s_arv = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t6_r_valid", 64'(s_rv), 64'h0);
        check("t6_mst_valid", 64'(m_arv), 64'h0);
        check("t6_ar_ready", 64'(s_arr), 64'h0);
        ar(0, 32'hF000_0000, 4'd2, 8'd0);
        #1;
        check("t6_new_ready", 64'(s_arr), 64'h1);
        step();
        s_arv = '0;
        #1;
        check("t6_new_valid", 64'(s_rv), 64'h1);
        check("t6_new_last", 64'(s_rlast), 64'h1);
        check("t6_new_id", 64'(s_rid[3:0]), 64'h2);
        step();
        check("t6_idle", 64'(s_rv), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
